// File: rtl/video_pattern_if.sv
// video_pattern_if: run/pattern controls into the generator and the timed pixel stream out of it.
interface video_pattern_if #(parameter int PPC = 2);
   logic i_enable;
   logic [2:0] i_mode;
   logic [23:0] i_solid_rgb;
   logic o_hs;
   logic o_vs;
   logic o_de;
   logic o_valid;
   logic [11:0] o_x;
   logic [11:0] o_y;
   logic [24*PPC-1:0] o_data;
   logic o_frame_start;
   logic [15:0] o_frame_cnt;
   logic o_busy;
   modport master(
      input i_enable, i_mode, i_solid_rgb,
      output o_hs, o_vs, o_de, o_valid, o_x, o_y, o_data, o_frame_start, o_frame_cnt, o_busy
   );
   modport slave(
      output i_enable, i_mode, i_solid_rgb,
      input o_hs, o_vs, o_de, o_valid, o_x, o_y, o_data, o_frame_start, o_frame_cnt, o_busy
   );
endinterface

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: frame-gated video timing with selectable RGB888 test patterns at PPC pixels per beat.
module video_pattern_gen #(
   parameter int HRES = 1080,
   parameter int VRES = 1920,
   parameter int HSP = 100,
   parameter int HBP = 100,
   parameter int HFP = 250,
   parameter int VSP = 3,
   parameter int VBP = 5,
   parameter int VFP = 6,
   parameter int PPC = 2,
   parameter bit SYNC_POL = 1'b1,
   parameter int CHK_LOG2 = 5,
   parameter int AUTO_LOG2 = 7
) (
   input logic i_pclk,
   input logic i_srst,
   video_pattern_if.master vp
);
   localparam logic [11:0] HTOT = 12'((HSP + HBP + HRES + HFP) / PPC);
   localparam logic [11:0] VTOT = 12'(VSP + VBP + VRES + VFP);
   localparam logic [11:0] HS_END = 12'(HSP / PPC);
   localparam logic [11:0] VS_END = 12'(VSP);
   localparam logic [11:0] H0 = 12'((HSP + HBP) / PPC);
   localparam logic [11:0] H1 = 12'((HSP + HBP + HRES) / PPC);
   localparam logic [11:0] V0 = 12'(VSP + VBP);
   localparam logic [11:0] V1 = 12'(VSP + VBP + VRES);
   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_n;
   logic [11:0] h, v, h_n, v_n, x_n, y_n;
   logic last_h, last, run, fs, hs_act, vs_act, de;
   logic [24*PPC-1:0] data_n;
   logic [15:0] frame_cnt;
   logic [2:0] mode_q;
   logic [23:0] solid_q;
   function automatic logic [23:0] pixel(input logic [2:0] m, input logic [11:0] px, input logic [11:0] y,
                                         input logic [15:0] fc, input logic [23:0] solid);
      logic [2:0] bar;
      logic [1:0] sel;
      logic [7:0] p8, gy, dg;
      bar = '0;
      for (int k = 1; k < 8; k++) bar = (px >= 12'(k * (HRES / 8))) ? 3'(k) : bar;
      p8 = px[7:0];
      gy = p8 + y[7:0];
      dg = gy + fc[7:0];
      sel = fc[AUTO_LOG2+1 -: 2];
      case (m)
         3'd0: pixel = solid;
         3'd1: pixel = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
         3'd2: pixel = {3{p8}};
         3'd3: pixel = {24{px[CHK_LOG2] ^ y[CHK_LOG2]}};
         3'd4: pixel = {3{dg}};
         3'd5: pixel = sel == 2'd0 ? {p8, 16'h0} : sel == 2'd1 ? {8'h0, p8, 8'h0} :
                       sel == 2'd2 ? {16'h0, p8} : {3{gy}};
         default: pixel = 24'h0;
      endcase
   endfunction
   always_ff @(posedge i_pclk)
      if (i_srst) begin
         state <= IDLE;
         h <= '0;
         v <= '0;
      end else begin
         state <= state_n;
         h <= h_n;
         v <= v_n;
      end
   // A frame only ends at its last beat; i_enable is ignored everywhere else in RUN.
   always_comb begin
      last_h = h == HTOT - 12'd1;
      last = last_h && v == VTOT - 12'd1;
      h_n = state == RUN ? (last_h ? '0 : h + 12'd1) : h;
      v_n = state == RUN && last_h ? (last ? '0 : v + 12'd1) : v;
      state_n = state == IDLE ? (vp.i_enable ? RUN : IDLE) : (last && !vp.i_enable ? IDLE : RUN);
   end
   always_comb begin
      run = state == RUN;
      fs = run && h == '0 && v == '0;
      hs_act = run && h < HS_END;
      vs_act = run && v < VS_END;
      de = run && h >= H0 && h < H1 && v >= V0 && v < V1;
      x_n = de ? (h - H0) * 12'(PPC) : '0;
      y_n = de ? v - V0 : '0;
      data_n = '0;
      for (int i = 0; i < PPC; i++)
         data_n[24*i +: 24] = de ? pixel(mode_q, x_n + 12'(i), y_n, frame_cnt, solid_q) : 24'h0;
   end
   always_ff @(posedge i_pclk)
      if (i_srst) begin
         vp.o_hs <= ~SYNC_POL;
         vp.o_vs <= ~SYNC_POL;
         vp.o_de <= 1'b0;
         vp.o_x <= '0;
         vp.o_y <= '0;
         vp.o_data <= '0;
         vp.o_frame_start <= 1'b0;
         vp.o_busy <= 1'b0;
         frame_cnt <= '0;
         mode_q <= '0;
         solid_q <= '0;
      end else begin
         vp.o_hs <= hs_act ~^ SYNC_POL;
         vp.o_vs <= vs_act ~^ SYNC_POL;
         vp.o_de <= de;
         vp.o_x <= x_n;
         vp.o_y <= y_n;
         vp.o_data <= data_n;
         vp.o_frame_start <= fs;
         vp.o_busy <= run;
         frame_cnt <= fs ? frame_cnt + 16'd1 : frame_cnt;
         mode_q <= fs ? vp.i_mode : mode_q;
         solid_q <= fs ? vp.i_solid_rgb : solid_q;
      end
   assign vp.o_valid = vp.o_de;
   assign vp.o_frame_cnt = frame_cnt;
endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen: directed checks of timing, patterns, frame gating and reset on small frames.
module tb_video_pattern_gen;
   logic clk = 1'b0;
   logic srst = 1'b1;
   int checks = 0;
   int errors = 0;
   int hs_n, vs_n, de_n, fs_n, busy_hits, h, v;
   logic exp_de;
   logic [7:0] b;
   logic [47:0] auto_exp [8];
   always #5 clk = ~clk;
   video_pattern_if #(.PPC(2)) vp();
   video_pattern_if #(.PPC(4)) vq();
   video_pattern_gen #(.HRES(16), .VRES(4), .HSP(2), .HBP(2), .HFP(4), .VSP(1), .VBP(1), .VFP(1),
      .PPC(2), .SYNC_POL(1'b1), .CHK_LOG2(2), .AUTO_LOG2(1)) dut (.i_pclk(clk), .i_srst(srst), .vp(vp.master));
   video_pattern_gen #(.HRES(32), .VRES(2), .HSP(4), .HBP(4), .HFP(4), .VSP(1), .VBP(1), .VFP(1),
      .PPC(4), .SYNC_POL(1'b1)) dut4 (.i_pclk(clk), .i_srst(srst), .vp(vq.master));
   task automatic step();
      @(negedge clk);
   endtask
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic chk_idle(input string tag, input logic [15:0] cnt);
      chk({tag, "_hs"}, vp.o_hs, 1'b0);
      chk({tag, "_vs"}, vp.o_vs, 1'b0);
      chk({tag, "_de"}, vp.o_de, 1'b0);
      chk({tag, "_valid"}, vp.o_valid, 1'b0);
      chk({tag, "_x"}, vp.o_x, 12'd0);
      chk({tag, "_y"}, vp.o_y, 12'd0);
      chk({tag, "_data"}, vp.o_data, 48'd0);
      chk({tag, "_fs"}, vp.o_frame_start, 1'b0);
      chk({tag, "_busy"}, vp.o_busy, 1'b0);
      chk({tag, "_cnt"}, vp.o_frame_cnt, cnt);
   endtask
   task automatic wait_fs(input string tag);
      int n = 0;
      while (!vp.o_frame_start && n < 200) begin
         step();
         n++;
      end
      chk(tag, vp.o_frame_start, 1'b1);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
   initial begin
      auto_exp = '{48'h030000_020000, 48'h000300_000200, 48'h000300_000200, 48'h000003_000002,
                   48'h000003_000002, 48'h030303_020202, 48'h030303_020202, 48'h030000_020000};
      vp.i_enable = 1'b0; vp.i_mode = 3'd0; vp.i_solid_rgb = 24'h0;
      vq.i_enable = 1'b0; vq.i_mode = 3'd1; vq.i_solid_rgb = 24'h0;
      repeat (3) step();
      chk_idle("reset", 16'd0);
      srst = 1'b0;
      busy_hits = 0;
      repeat (200) begin
         step();
         busy_hits += int'(vp.o_busy) + int'(vp.o_hs) + int'(vp.o_frame_start);
      end
      chk("idle_quiet", busy_hits, 0);
      // colour bars at four pixels per beat: bar width is 4 pixels
      vq.i_enable = 1'b1;
      begin
         int n = 0;
         while (!vq.o_frame_start && n < 100) begin
            step();
            n++;
         end
      end
      chk("bars_fs", vq.o_frame_start, 1'b1);
      repeat (24) step();
      chk("bars_x0", vq.o_data, {4{24'hFFFFFF}});
      repeat (4) step();
      chk("bars_x16", vq.o_data, {4{24'hFF00FF}});
      step();
      chk("bars_x20_x", vq.o_x, 12'd20);
      chk("bars_x20", vq.o_data, {4{24'hFF0000}});
      repeat (2) step();
      chk("bars_x28_de", vq.o_de, 1'b1);
      chk("bars_x28", vq.o_data, 96'd0);
      vq.i_enable = 1'b0;
      // frame timing in gray ramp mode
      vp.i_mode = 3'd2;
      vp.i_enable = 1'b1;
      step();
      chk("start_lat1", vp.o_frame_start, 1'b0);
      step();
      chk("start_fs", vp.o_frame_start, 1'b1);
      chk("start_cnt", vp.o_frame_cnt, 16'd1);
      chk("start_busy", vp.o_busy, 1'b1);
      hs_n = 0; vs_n = 0; de_n = 0; fs_n = 0;
      for (int t = 0; t < 84; t++) begin
         h = t % 12;
         v = t / 12;
         exp_de = h >= 2 && h < 10 && v >= 2 && v < 6;
         hs_n += int'(vp.o_hs);
         vs_n += int'(vp.o_vs);
         de_n += int'(vp.o_de);
         fs_n += int'(vp.o_frame_start);
         chk("f_de", vp.o_de, exp_de);
         chk("f_valid", vp.o_valid, exp_de);
         chk("f_busy", vp.o_busy, 1'b1);
         if (exp_de) begin
            b = 8'((h - 2) * 2);
            chk("f_x", vp.o_x, {4'd0, b});
            chk("f_y", vp.o_y, 12'(v - 2));
            chk("f_data", vp.o_data, {{3{b + 8'd1}}, {3{b}}});
         end
         step();
      end
      chk("f_hs_beats", hs_n, 7);
      chk("f_vs_beats", vs_n, 12);
      chk("f_de_beats", de_n, 32);
      chk("f_fs_beats", fs_n, 1);
      chk("f_second_fs", vp.o_frame_start, 1'b1);
      chk("f_second_cnt", vp.o_frame_cnt, 16'd2);
      // mode latching at frame boundaries, then a clean stop
      srst = 1'b1; vp.i_enable = 1'b0; vp.i_mode = 3'd0; vp.i_solid_rgb = 24'h123456;
      step();
      srst = 1'b0; vp.i_enable = 1'b1;
      step();
      step();
      chk("ml_fs", vp.o_frame_start, 1'b1);
      chk("ml_cnt", vp.o_frame_cnt, 16'd1);
      repeat (26) step();
      chk("ml_solid", vp.o_data, {2{24'h123456}});
      repeat (14) step();
      vp.i_mode = 3'd3;
      repeat (10) step();
      chk("ml_solid_held", vp.o_data, {2{24'h123456}});
      repeat (34) step();
      chk("ml_fs2", vp.o_frame_start, 1'b1);
      repeat (28) step();
      chk("ml_chk_white", vp.o_data, {2{24'hFFFFFF}});
      repeat (2) step();
      chk("ml_chk_black_de", vp.o_de, 1'b1);
      chk("ml_chk_black", vp.o_data, 48'd0);
      repeat (10) step();
      vp.i_enable = 1'b0;
      repeat (43) step();
      chk("stop_last_busy", vp.o_busy, 1'b1);
      step();
      chk_idle("stop", 16'd2);
      repeat (20) step();
      chk("stop_stays", vp.o_busy, 1'b0);
      // auto mode cycling every two frames, then moving diagonal
      srst = 1'b1; vp.i_mode = 3'd5; vp.i_enable = 1'b1;
      step();
      srst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         wait_fs("auto_fs");
         chk("auto_cnt", vp.o_frame_cnt, 16'(k + 1));
         repeat (27) step();
         chk("auto_data", vp.o_data, auto_exp[k]);
      end
      vp.i_mode = 3'd4;
      wait_fs("diag_fs");
      chk("diag_cnt", vp.o_frame_cnt, 16'd9);
      repeat (27) step();
      chk("diag_data", vp.o_data, 48'h0C0C0C_0B0B0B);
      // reset in the middle of an active line
      repeat (13) step();
      chk("mr_de", vp.o_de, 1'b1);
      srst = 1'b1;
      step();
      chk_idle("mr", 16'd0);
      srst = 1'b0;
      step();
      chk("mr_lat1", vp.o_frame_start, 1'b0);
      step();
      chk("mr_fs", vp.o_frame_start, 1'b1);
      chk("mr_cnt", vp.o_frame_cnt, 16'd1);
      chk("mr_busy", vp.o_busy, 1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
